// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder sequencer: FSM encodings and the default width.
package serial_adder_pkg;
   localparam int DEF_WIDTH = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HOLD = 2'd2
   } state_t;
endpackage

// File: rtl/fa_bit_slice.sv
// One-bit full adder slice, time-shared by the serial adder sequencer.
module fa_bit_slice (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic co
);
   assign s  = a ^ b ^ cin;
   assign co = (a & b) | (a & cin) | (b & cin);
endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: operands are accepted over a valid/ready handshake, added LSB-first
// one bit per clock through a single full-adder slice, and presented until consumed.
module serial_adder_ctrl
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);
   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] sum_sr;
   logic [WIDTH-1:0] sum_shift;
   logic [WIDTH-1:0] sum_q;
   logic             carry;
   logic             cout_q;
   logic             slice_s;
   logic             slice_co;
   logic             last_bit;

   fa_bit_slice u_slice (
      .a   (a_sr[0]),
      .b   (b_sr[0]),
      .cin (carry),
      .s   (slice_s),
      .co  (slice_co)
   );

   // New bit enters at the MSB; after WIDTH shifts the LSB of the result sits at bit 0.
   assign sum_shift = (sum_sr >> 1) | {slice_s, {(WIDTH-1){1'b0}}};
   assign last_bit  = (cnt == CNT_W'(WIDTH-1));

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (in_valid)  state_nxt = ST_RUN;
         ST_RUN:  if (last_bit)  state_nxt = ST_HOLD;
         ST_HOLD: if (out_ready) state_nxt = ST_IDLE;
         default:                state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   // Separate result registers keep sum/cout stable while the next operation is in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt    <= '0;
         a_sr   <= '0;
         b_sr   <= '0;
         sum_sr <= '0;
         sum_q  <= '0;
         carry  <= 1'b0;
         cout_q <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  a_sr  <= a;
                  b_sr  <= b;
                  carry <= cin;
                  cnt   <= '0;
               end
            end
            ST_RUN: begin
               a_sr   <= a_sr >> 1;
               b_sr   <= b_sr >> 1;
               sum_sr <= sum_shift;
               carry  <= slice_co;
               cnt    <= cnt + 1'b1;
               if (last_bit) begin
                  sum_q  <= sum_shift;
                  cout_q <= slice_co;
               end
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = (state == ST_IDLE);
   assign out_valid = (state == ST_HOLD);
   assign sum       = sum_q;
   assign cout      = cout_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed and randomized checks of the bit-serial adder sequencer at WIDTH=8.
module tb_serial_adder_ctrl;
   import serial_adder_pkg::*;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] sum;
   logic         cout;

   int n_assert = 0;
   int n_fail   = 0;

   serial_adder_ctrl #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present operands for exactly the edge that accepts them.
   task automatic accept(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
      int guard;
      guard = 0;
      while (!in_ready && guard < 100) begin
         step();
         guard++;
      end
      check("in_ready_wait", {63'd0, in_ready}, 64'd1);
      a        = av;
      b        = bv;
      cin      = cv;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
   endtask

   task automatic wait_result(output int cyc);
      cyc = 0;
      while (!out_valid && cyc < 100) begin
         step();
         cyc++;
      end
      check("out_valid_wait", {63'd0, out_valid}, 64'd1);
   endtask

   task automatic add_check(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                            input logic cv, input logic [W-1:0] es, input logic ec);
      int cyc;
      accept(av, bv, cv);
      wait_result(cyc);
      check({tag, "_sum"},  {56'd0, sum}, {56'd0, es});
      check({tag, "_cout"}, {63'd0, cout}, {63'd0, ec});
      step();
      check({tag, "_idle"}, {62'd0, dut.state}, {62'd0, ST_IDLE});
   endtask

   initial begin
      int          cyc;
      int          accepts;
      int          handshakes;
      logic [W-1:0] hs;
      logic         hc;
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic         rc;
      logic [W:0]   rexp;
      bit           done;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      a         = '0;
      b         = '0;
      cin       = 1'b0;
      out_ready = 1'b1;
      #2;
      check("rst_state",     {62'd0, dut.state}, {62'd0, ST_IDLE});
      check("rst_out_valid", {63'd0, out_valid}, 64'd0);
      check("rst_sum",       {56'd0, sum}, 64'd0);
      check("rst_cout",      {63'd0, cout}, 64'd0);
      step();
      step();
      rst_n = 1'b1;
      step();
      check("rst_in_ready", {63'd0, in_ready}, 64'd1);

      // Latency: accept at edge k, out_valid seen after edge k+8.
      accept(8'h0F, 8'h01, 1'b0);
      wait_result(cyc);
      check("latency",    cyc, 64'd8);
      check("t1_sum",     {56'd0, sum}, 64'h10);
      check("t1_cout",    {63'd0, cout}, 64'd0);
      step();
      check("t1_hold_1cyc", {63'd0, out_valid}, 64'd0);
      check("t1_in_ready",  {63'd0, in_ready}, 64'd1);

      add_check("ovf",     8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
      add_check("all_one", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);

      // Back-pressure: result must stay put while out_ready is low.
      out_ready = 1'b0;
      accept(8'hA5, 8'h3C, 1'b1);
      wait_result(cyc);
      for (int i = 0; i < 5; i++) begin
         check("bp_valid", {63'd0, out_valid}, 64'd1);
         check("bp_sum",   {56'd0, sum}, 64'hE2);
         check("bp_cout",  {63'd0, cout}, 64'd0);
         step();
      end
      out_ready = 1'b1;
      step();
      check("bp_idle",  {62'd0, dut.state}, {62'd0, ST_IDLE});
      check("bp_valid_low", {63'd0, out_valid}, 64'd0);

      // Request during RUN is ignored.
      accept(8'h03, 8'h04, 1'b0);
      for (int i = 0; i < 7; i++) begin
         if (i == 2) begin
            a = 8'h55; b = 8'h55; cin = 1'b1; in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         check("run_in_ready", {63'd0, in_ready}, 64'd0);
         step();
      end
      in_valid = 1'b0;
      wait_result(cyc);
      check("ign_sum",  {56'd0, sum}, 64'h07);
      check("ign_cout", {63'd0, cout}, 64'd0);
      step();
      check("ign_idle", {62'd0, dut.state}, {62'd0, ST_IDLE});

      // Asynchronous reset in the middle of RUN.
      accept(8'h11, 8'h22, 1'b0);
      step(); step(); step(); step();
      check("mid_cnt",   {{(64-$bits(dut.cnt)){1'b0}}, dut.cnt}, 64'd4);
      check("mid_state", {62'd0, dut.state}, {62'd0, ST_RUN});
      rst_n = 1'b0;
      #1;
      check("mid_rst_state", {62'd0, dut.state}, {62'd0, ST_IDLE});
      check("mid_rst_sum",   {56'd0, sum}, 64'd0);
      check("mid_rst_cout",  {63'd0, cout}, 64'd0);
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         check("mid_no_valid", {63'd0, out_valid}, 64'd0);
         step();
      end
      add_check("post_rst", 8'h20, 8'h22, 1'b0, 8'h42, 1'b0);

      // Random operands with random back-pressure.
      accepts    = 0;
      handshakes = 0;
      for (int t = 0; t < 1000; t++) begin
         ra   = W'($urandom);
         rb   = W'($urandom);
         rc   = 1'($urandom_range(0, 1));
         rexp = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
         accept(ra, rb, rc);
         accepts++;
         done = 1'b0;
         for (int c = 0; c < 200 && !done; c++) begin
            out_ready = 1'($urandom_range(0, 1));
            if (out_valid && out_ready) begin
               hs = sum;
               hc = cout;
               check("rnd_sum",  {56'd0, hs}, {56'd0, rexp[W-1:0]});
               check("rnd_cout", {63'd0, hc}, {63'd0, rexp[W]});
               handshakes++;
               step();
               check("rnd_no_dup", {63'd0, out_valid}, 64'd0);
               done = 1'b1;
            end else begin
               step();
            end
         end
         check("rnd_done", {63'd0, done}, 64'd1);
      end
      out_ready = 1'b1;
      check("rnd_count", handshakes, accepts);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
